// File: rtl/f3m_mult_seq.sv
// f3m_mult_seq: sequential GF(3^97) multiplier, C = A*B mod (x^97 + x^12 + 2).
// B is consumed most-significant digit first with Horner steps:
//   acc <- acc*x mod P + b_i*A
// Digit encoding: 00=0, 01=1, 10=2 (11 never expected on inputs).
// Build options:
//   `M                   field degree, fixed at 97 here.
//   F3M_MULT_2DIGIT_EN   two chained Horner steps per cycle (49-cycle latency);
//                        undefined gives one step per cycle (97-cycle latency).

`define M 97

package f3m_pkg;
    localparam int M    = `M;
    localparam int W    = 2 * M;
    // x^97 folds to 2*x^12 + 1
    localparam int FOLD = 12;

    // GF(3) addition on 2-bit encoded digits
    function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 3'd3)
            s = s - 3'd3;
        return s[1:0];
    endfunction

    // GF(3) multiplication: 1*1=1, 2*2=1, 1*2=2, anything*0=0
    function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] r;
        if (x == 2'b00 || y == 2'b00)
            r = 2'b00;
        else if (x == y)
            r = 2'b01;
        else
            r = 2'b10;
        return r;
    endfunction
endpackage

// Combinational multiply-by-x with one reduction. The input must have all
// digits >= 97 zero, so digit 96 is the only one that overflows.
module f3m_mulx
    import f3m_pkg::*;
(
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    logic [1:0] top;
    assign top = a[W-1 -: 2];

    for (genvar i = 0; i < M; i++) begin : g_dig
        if (i == 0) begin : g_d0
            // constant term of the fold: 1 * top
            assign y[1:0] = top;
        end else if (i == FOLD) begin : g_dfold
            // x^12 term of the fold: 2 * top added onto the shifted digit
            assign y[2*i +: 2] = gf3_add(a[2*(i-1) +: 2], gf3_mul(2'b10, top));
        end else begin : g_dshift
            assign y[2*i +: 2] = a[2*(i-1) +: 2];
        end
    end
endmodule

// One Horner step: y = acc*x mod P + bd*a, digit-wise in GF(3)
module f3m_horner_step
    import f3m_pkg::*;
(
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic [1:0]   bd,
    output logic [W-1:0] y
);
    logic [W-1:0] t;

    f3m_mulx u_mulx (
        .a (acc),
        .y (t)
    );

    for (genvar i = 0; i < M; i++) begin : g_mac
        assign y[2*i +: 2] = gf3_add(t[2*i +: 2], gf3_mul(bd, a[2*i +: 2]));
    end
endmodule

module f3m_mult_seq
    import f3m_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] C,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;

`ifdef F3M_MULT_2DIGIT_EN
    localparam logic [6:0] CNT_INIT = 7'd48;
`else
    localparam logic [6:0] CNT_INIT = 7'd96;
`endif

    state_t       state;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] acc;
    logic [W-1:0] acc_nxt;
    logic [6:0]   cnt;

`ifdef F3M_MULT_2DIGIT_EN
    // B extended to 98 digits; the implicit top digit is zero so step
    // pair j=48 starts with a harmless 0*A term.
    logic [W+1:0] rb_ext;
    logic [8:0]   lo_bit;
    logic [1:0]   d_hi;
    logic [1:0]   d_lo;
    logic [W-1:0] t1;

    assign rb_ext = {2'b00, rb};
    assign lo_bit = {cnt, 2'b00};
    assign d_hi   = rb_ext[lo_bit + 9'd2 +: 2];
    assign d_lo   = rb_ext[lo_bit +: 2];

    f3m_horner_step u_step_hi (
        .acc (acc),
        .a   (ra),
        .bd  (d_hi),
        .y   (t1)
    );

    f3m_horner_step u_step_lo (
        .acc (t1),
        .a   (ra),
        .bd  (d_lo),
        .y   (acc_nxt)
    );
`else
    logic [7:0] bit_idx;
    logic [1:0] d_cur;

    assign bit_idx = {cnt, 1'b0};
    assign d_cur   = rb[bit_idx +: 2];

    f3m_horner_step u_step (
        .acc (acc),
        .a   (ra),
        .bd  (d_cur),
        .y   (acc_nxt)
    );
`endif

    // Control FSM: capture operands on start, iterate cnt down to 0, then
    // publish the product with a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            C     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= A;
                        rb    <= B;
                        acc   <= '0;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (cnt == 7'd0) begin
                        C     <= acc_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
